// File: rtl/router_modport.sv
// router_modport
// Destination-side output port of the 1x3 packet router, one instance per
// output channel. Bytes written by the router core are buffered in a FIFO
// together with a header marker, then handed to the downstream reader
// through a valid_out / read_enable handshake. If data sits unread for
// TIMEOUT cycles the block pulses soft_reset and flushes itself so the
// router can recover from an abandoned packet.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   resetn       asynchronous active-low reset
//   write_enb    write strobe from the router core
//   data_in      byte to store
//   lfd_state    marks data_in as a packet header byte
//   read_enable  read request from the destination
//   valid_out    FIFO non-empty
//   full         FIFO holds DEPTH entries
//   empty        FIFO holds zero entries
//   data_out     registered read data
//   soft_reset   one-cycle timeout pulse
module router_modport #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lfd_state,
  input  logic             read_enable,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out,
  output logic             soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = WIDTH - 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Each entry carries the header marker in its top bit.
  logic [WIDTH:0]   mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [KW-1:0]    pkt_q, pkt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             soft_reset_q, soft_reset_d;

  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH:0]   head;

  assign empty      = (count_q == '0);
  assign full       = (count_q == PW'(DEPTH));
  assign valid_out  = !empty;
  assign data_out   = data_out_q;
  assign soft_reset = soft_reset_q;

  // The flush edge wins over any transfer in flight, so neither side is
  // accepted while soft_reset is high.
  assign wr_accept = write_enb && !full && !soft_reset_q;
  assign rd_accept = read_enable && !empty && !soft_reset_q;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Next-state logic for pointers, occupancy, packet tracking and timeout.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pkt_d        = pkt_q;
    timer_d      = timer_q;
    data_out_d   = data_out_q;
    soft_reset_d = 1'b0;

    if (soft_reset_q) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pkt_d      = '0;
      timer_d    = '0;
      data_out_d = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end

      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase

      // A header byte reloads the remaining-byte count (payload + parity);
      // once a packet is fully drained and the FIFO is empty, data_out idles at 0.
      if (rd_accept) begin
        data_out_d = head[WIDTH-1:0];
        if (head[WIDTH]) begin
          pkt_d = KW'(head[WIDTH-1:2]) + KW'(1);
        end else if (pkt_q != '0) begin
          pkt_d = pkt_q - KW'(1);
        end
      end else if (empty && (pkt_q == '0)) begin
        data_out_d = '0;
      end

      // Idle-read counter saturates so it never wraps back into a second pulse.
      if (read_enable || empty) begin
        timer_d = '0;
      end else if (timer_q != TW'(TIMEOUT)) begin
        timer_d = timer_q + TW'(1);
      end

      soft_reset_d = (timer_q == TW'(TIMEOUT - 1)) && !read_enable && !empty;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_q        <= '0;
      timer_q      <= '0;
      data_out_q   <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_q        <= pkt_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      soft_reset_q <= soft_reset_d;
    end
  end

endmodule

// File: tb/tb_router_modport.sv
// tb_router_modport
// Bench for router_modport. Inputs are driven 1 time unit after each rising
// edge and outputs are sampled at the same point, mirroring how the
// destination reader behaves.
module tb_router_modport;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  logic       clock       = 1'b0;
  logic       resetn      = 1'b0;
  logic       write_enb   = 1'b0;
  logic [7:0] data_in     = 8'h00;
  logic       lfd_state   = 1'b0;
  logic       read_enable = 1'b0;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic [7:0] data_out;
  logic       soft_reset;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: a queue of {header, byte} plus the packet,
  // idle-time and output-byte bookkeeping the port is expected to keep.
  logic [8:0] mQueue [$];
  int         mRemaining;
  int         mTimer;
  bit         mSoft;
  logic [7:0] mDout;
  bit         mReadTaken;
  bit         mWriteTaken;

  router_modport #(
    .DEPTH(16),
    .WIDTH(8),
    .TIMEOUT(30)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .write_enb(write_enb),
    .data_in(data_in),
    .lfd_state(lfd_state),
    .read_enable(read_enable),
    .valid_out(valid_out),
    .full(full),
    .empty(empty),
    .data_out(data_out),
    .soft_reset(soft_reset)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Safety net in case something stalls forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    mQueue.delete();
    mRemaining  = 0;
    mTimer      = 0;
    mSoft       = 1'b0;
    mDout       = 8'h00;
    mReadTaken  = 1'b0;
    mWriteTaken = 1'b0;
  endfunction

  // Advance the reference by one clock edge using the inputs currently driven.
  function automatic void modelEdge();
    bit         wasEmpty;
    bit         wasFull;
    bit         nextSoft;
    logic [8:0] item;
    mReadTaken  = 1'b0;
    mWriteTaken = 1'b0;
    if (mSoft) begin
      modelReset();
      return;
    end
    wasEmpty = (mQueue.size() == 0);
    wasFull  = (mQueue.size() == DEPTH);
    nextSoft = (mTimer == TIMEOUT - 1) && !read_enable && !wasEmpty;
    if (read_enable || wasEmpty) mTimer = 0;
    else if (mTimer < TIMEOUT) mTimer++;
    if (read_enable && !wasEmpty) begin
      item       = mQueue.pop_front();
      mDout      = item[7:0];
      mReadTaken = 1'b1;
      if (item[8]) mRemaining = int'(item[7:2]) + 1;
      else if (mRemaining > 0) mRemaining--;
    end else if (wasEmpty && mRemaining == 0) begin
      mDout = 8'h00;
    end
    if (write_enb && !wasFull) begin
      mQueue.push_back({lfd_state, data_in});
      mWriteTaken = 1'b1;
    end
    mSoft = nextSoft;
  endfunction

  // One clock: update the reference, then land 1 unit after the edge.
  task automatic tick();
    if (resetn) modelEdge();
    @(posedge clock);
    #1;
  endtask

  // Power-on reset values, then an asynchronous reset asserted mid-run.
  task automatic test_reset();
    resetn = 1'b0;
    modelReset();
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %02h expected 00", data_out); end
    @(posedge clock);
    #1;
    resetn = 1'b1;
    write_enb = 1'b1; data_in = 8'h5A; tick();
    data_in = 8'hA5; tick();
    write_enb = 1'b0; read_enable = 1'b1; tick();
    read_enable = 1'b0;
    checks++; if (data_out !== 8'h5A) begin failures++; $display("[TB] FAIL pre_reset_data: got %02h expected 5a", data_out); end
    #2;
    resetn = 1'b0;
    modelReset();
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL midrun_reset_empty: got %b expected 1", empty); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL midrun_reset_valid: got %b expected 0", valid_out); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL midrun_reset_full: got %b expected 0", full); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL midrun_reset_data: got %02h expected 00", data_out); end
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Header 0x0C (3 payload bytes) plus parity, read back continuously.
  task automatic test_round_trip();
    logic [7:0] pkt [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h3C};
    for (int i = 0; i < 5; i++) begin
      write_enb = 1'b1;
      lfd_state = (i == 0);
      data_in   = pkt[i];
      tick();
    end
    write_enb = 1'b0; lfd_state = 1'b0;
    read_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (data_out !== pkt[i]) begin failures++; $display("[TB] FAIL round_trip_byte%0d: got %02h expected %02h", i, data_out, pkt[i]); end
    end
    read_enable = 1'b0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL round_trip_valid: got %b expected 0", valid_out); end
    tick();
    checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL round_trip_idle_data: got %02h expected 00", data_out); end
    checks++; if (data_out !== mDout) begin failures++; $display("[TB] FAIL round_trip_model: got %02h expected %02h", data_out, mDout); end
  endtask

  // Seventeen writes into a 16-entry FIFO: the last one must be dropped.
  task automatic test_full();
    for (int i = 0; i < 17; i++) begin
      write_enb = 1'b1; data_in = 8'(i);
      tick();
      if (i < 15) begin
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL full_early%0d: got %b expected 0", i, full); end
      end else begin
        checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL full_set%0d: got %b expected 1", i, full); end
      end
    end
    write_enb = 1'b0;
    read_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (data_out !== 8'(i)) begin failures++; $display("[TB] FAIL full_read%0d: got %02h expected %02h", i, data_out, 8'(i)); end
    end
    read_enable = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL full_drained_empty: got %b expected 1", empty); end
    tick();
  endtask

  // Simultaneous read and write while full: only the read goes through.
  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) begin
      write_enb = 1'b1; data_in = 8'(8'h40 + i);
      tick();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL simul_pre_full: got %b expected 1", full); end
    data_in = 8'hAA; read_enable = 1'b1;
    tick();
    write_enb = 1'b0;
    checks++; if (data_out !== 8'h40) begin failures++; $display("[TB] FAIL simul_data: got %02h expected 40", data_out); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL simul_full_after: got %b expected 0", full); end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (data_out !== 8'(8'h40 + i)) begin failures++; $display("[TB] FAIL simul_read%0d: got %02h expected %02h", i, data_out, 8'(8'h40 + i)); end
    end
    read_enable = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL simul_aa_dropped: empty=%b expected 1", empty); end
    tick();
  endtask

  // Random interleaving of 40 incrementing bytes across the pointer wrap.
  task automatic test_wrap_random();
    int         written = 0;
    int         readCnt = 0;
    int         cycles  = 0;
    logic [7:0] base    = 8'($urandom);
    lfd_state = 1'b0;
    while ((written < 40 || mQueue.size() != 0) && cycles < 2000) begin
      write_enb   = (written < 40) && ($urandom_range(0, 1) == 1);
      data_in     = base + 8'(written);
      read_enable = ($urandom_range(0, 1) == 1);
      tick();
      cycles++;
      if (mWriteTaken) written++;
      if (mReadTaken) begin
        checks++; if (data_out !== 8'(base + 8'(readCnt))) begin failures++; $display("[TB] FAIL wrap_seq%0d: got %02h expected %02h", readCnt, data_out, 8'(base + 8'(readCnt))); end
        readCnt++;
      end
      checks++; if (empty !== (mQueue.size() == 0)) begin failures++; $display("[TB] FAIL wrap_empty cyc%0d: got %b expected %b", cycles, empty, (mQueue.size() == 0)); end
      checks++; if (full !== (mQueue.size() == DEPTH)) begin failures++; $display("[TB] FAIL wrap_full cyc%0d: got %b expected %b", cycles, full, (mQueue.size() == DEPTH)); end
      checks++; if (data_out !== mDout) begin failures++; $display("[TB] FAIL wrap_model_data cyc%0d: got %02h expected %02h", cycles, data_out, mDout); end
    end
    write_enb = 1'b0; read_enable = 1'b0;
    checks++; if (readCnt !== 40) begin failures++; $display("[TB] FAIL wrap_count: got %0d expected 40", readCnt); end
    tick();
  endtask

  // Abandoned packet timeout, then a read at the last moment that averts it.
  task automatic test_timeout();
    int n;
    bit seen;
    lfd_state = 1'b0; read_enable = 1'b0;
    write_enb = 1'b1; data_in = 8'h05; tick();
    data_in = 8'h06; tick();
    write_enb = 1'b0;
    n = 1;
    while (soft_reset !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++; if (n !== 30) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d expected 30", n); end
    checks++; if (mSoft !== 1'b1) begin failures++; $display("[TB] FAIL timeout_model: got %b expected 1", mSoft); end
    tick();
    checks++; if (soft_reset !== 1'b0) begin failures++; $display("[TB] FAIL timeout_pulse_width: got %b expected 0", soft_reset); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flush_empty: got %b expected 1", empty); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL timeout_flush_data: got %02h expected 00", data_out); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (soft_reset === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL timeout_rearmed: got %b expected 0", seen); end

    write_enb = 1'b1; data_in = 8'h07; tick();
    data_in = 8'h08; tick();
    write_enb = 1'b0;
    for (int k = 2; k <= 29; k++) tick();
    checks++; if (soft_reset !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %b expected 0", soft_reset); end
    read_enable = 1'b1; tick();
    read_enable = 1'b0;
    checks++; if (soft_reset !== 1'b0) begin failures++; $display("[TB] FAIL timeout_saved: got %b expected 0", soft_reset); end
    checks++; if (data_out !== 8'h07) begin failures++; $display("[TB] FAIL timeout_saved_data: got %02h expected 07", data_out); end
    seen = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (soft_reset === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL timeout_restart: got %b expected 0", seen); end
    read_enable = 1'b1; tick();
    read_enable = 1'b0;
    checks++; if (data_out !== 8'h08) begin failures++; $display("[TB] FAIL timeout_last_data: got %02h expected 08", data_out); end
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL timeout_end_empty: got %b expected 1", empty); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL timeout_end_data: got %02h expected 00", data_out); end
  endtask

  // Run every scenario in order and report.
  initial begin
    modelReset();
    $display("[TB] starting router_modport bench");
    test_reset();
    test_round_trip();
    test_full();
    test_simul_full();
    test_wrap_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
